// File: rtl/dhcp_rx_parser.sv
// DHCP client receive parser: validates the BOOTP header, walks the options TLVs
// byte by byte and issues one-cycle OFFER/ACK/NAK/drop verdicts with lease fields.
module dhcp_rx_parser #(
  parameter int DATA_W        = 16,
  parameter bit XID_CHECK     = 1'b1,
  parameter int MAX_OPT_BYTES = 312
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              validin,
  input  logic              sof,
  input  logic              eof,
  input  logic [DATA_W-1:0] datain,
  input  logic              checksummatch,
  input  logic [47:0]       local_mac,
  input  logic [31:0]       expected_xid,
  output logic              dhcpoffer,
  output logic              dhcpacknowledge,
  output logic              dhcpnak,
  output logic              rx_drop,
  output logic [31:0]       yiaddr,
  output logic [31:0]       siaddr,
  output logic [31:0]       server_id,
  output logic [31:0]       subnet_mask,
  output logic [31:0]       router,
  output logic [31:0]       lease_time
);

  localparam int BPB = DATA_W / 8;
  localparam logic [31:0] COOKIE = 32'h63825363;

  typedef enum logic [2:0] {IDLE, HDR, TAG, LEN, VAL, DONE} state_t;

  // Per-frame context: offset/counters, check flags, TLV walker and shadow fields.
  typedef struct packed {
    logic [8:0]  offset;
    logic [9:0]  opt_cnt;
    logic        hdr_ok;
    logic        end_seen;
    logic        msg_seen;
    logic [7:0]  msgtype;
    logic [7:0]  tag;
    logic [7:0]  len;
    logic [7:0]  vcnt;
    logic [31:0] shift;
    logic [31:0] yiaddr;
    logic [31:0] siaddr;
    logic [31:0] server_id;
    logic [31:0] subnet_mask;
    logic [31:0] router;
    logic [31:0] lease_time;
  } ctx_t;

  state_t      state, state_n;
  ctx_t        ctx, ctx_n;
  logic        accept, drop;
  logic [7:0]  b;
  logic [9:0]  sum;
  logic [8:0]  off;
  logic [2:0]  mac_idx;
  logic [31:0] shv;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ctx   <= '0;
    end else begin
      state <= state_n;
      ctx   <= ctx_n;
    end
  end

  // Lanes are walked in order within one beat, so each byte sees the effect of the previous one.
  always_comb begin
    state_n = state;
    ctx_n   = ctx;
    accept  = 1'b0;
    drop    = 1'b0;
    b       = '0;
    sum     = '0;
    off     = '0;
    mac_idx = '0;
    shv     = '0;

    if (validin && sof && eof) begin
      drop    = 1'b1;
      state_n = IDLE;
    end else if (validin && (sof || state != IDLE)) begin
      if (sof) begin
        ctx_n        = '0;
        ctx_n.hdr_ok = 1'b1;
        state_n      = HDR;
      end
      for (int l = 0; l < BPB; l++) begin
        b   = datain[8*l +: 8];
        sum = {1'b0, ctx_n.offset} + 10'(l);
        off = sum[9] ? 9'd511 : sum[8:0];
        if (state_n == HDR) begin
          mac_idx = 3'(off - 9'd28);
          if (off == 9'd0) begin
            if (b != 8'h02) ctx_n.hdr_ok = 1'b0;
          end else if (off == 9'd1) begin
            if (b != 8'h01) ctx_n.hdr_ok = 1'b0;
          end else if (off == 9'd2) begin
            if (b != 8'h06) ctx_n.hdr_ok = 1'b0;
          end else if (off >= 9'd4 && off <= 9'd7) begin
            if (XID_CHECK && b != expected_xid[{2'd3 - off[1:0], 3'b000} +: 8])
              ctx_n.hdr_ok = 1'b0;
          end else if (off >= 9'd16 && off <= 9'd19) begin
            ctx_n.yiaddr = {ctx_n.yiaddr[23:0], b};
          end else if (off >= 9'd20 && off <= 9'd23) begin
            ctx_n.siaddr = {ctx_n.siaddr[23:0], b};
          end else if (off >= 9'd28 && off <= 9'd33) begin
            if (b != local_mac[{3'd5 - mac_idx, 3'b000} +: 8]) ctx_n.hdr_ok = 1'b0;
          end else if (off >= 9'd236) begin
            if (b != COOKIE[{2'd3 - off[1:0], 3'b000} +: 8]) ctx_n.hdr_ok = 1'b0;
            if (off == 9'd239) state_n = TAG;
          end
        end else begin
          if (ctx_n.opt_cnt != 10'h3FF) ctx_n.opt_cnt = ctx_n.opt_cnt + 10'd1;
          case (state_n)
            TAG: begin
              if (b == 8'd255) begin
                state_n        = DONE;
                ctx_n.end_seen = 1'b1;
              end else if (b != 8'd0) begin
                ctx_n.tag = b;
                state_n   = LEN;
              end
            end
            LEN: begin
              ctx_n.len  = b;
              ctx_n.vcnt = '0;
              state_n    = (b == 8'd0) ? TAG : VAL;
            end
            VAL: begin
              shv         = {ctx_n.shift[23:0], b};
              ctx_n.shift = shv;
              if (ctx_n.vcnt == 8'd0 && ctx_n.tag == 8'd53 && ctx_n.len == 8'd1) begin
                ctx_n.msgtype  = b;
                ctx_n.msg_seen = 1'b1;
              end
              // Four-byte values commit on their last byte; bad lengths never commit.
              if (ctx_n.vcnt == 8'd3) begin
                if (ctx_n.len == 8'd4) begin
                  if (ctx_n.tag == 8'd1)  ctx_n.subnet_mask = shv;
                  if (ctx_n.tag == 8'd51) ctx_n.lease_time  = shv;
                  if (ctx_n.tag == 8'd54) ctx_n.server_id   = shv;
                end
                if (ctx_n.tag == 8'd3 && ctx_n.len[1:0] == 2'b00) ctx_n.router = shv;
              end
              if (ctx_n.vcnt == ctx_n.len - 8'd1) state_n = TAG;
              ctx_n.vcnt = ctx_n.vcnt + 8'd1;
            end
            default: ;
          endcase
        end
      end
      sum          = {1'b0, ctx_n.offset} + 10'(BPB);
      ctx_n.offset = sum[9] ? 9'd511 : sum[8:0];

      if (eof) begin
        state_n = IDLE;
        if (ctx_n.hdr_ok && ctx_n.end_seen && ctx_n.msg_seen && checksummatch &&
            int'(ctx_n.opt_cnt) <= MAX_OPT_BYTES &&
            (ctx_n.msgtype == 8'd2 || ctx_n.msgtype == 8'd5 || ctx_n.msgtype == 8'd6))
          accept = 1'b1;
        else
          drop = 1'b1;
      end
    end
  end

  // Verdict pulses and the shadow-to-output transfer land on the eof edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dhcpoffer       <= 1'b0;
      dhcpacknowledge <= 1'b0;
      dhcpnak         <= 1'b0;
      rx_drop         <= 1'b0;
      yiaddr          <= '0;
      siaddr          <= '0;
      server_id       <= '0;
      subnet_mask     <= '0;
      router          <= '0;
      lease_time      <= '0;
    end else begin
      dhcpoffer       <= accept && ctx_n.msgtype == 8'd2;
      dhcpacknowledge <= accept && ctx_n.msgtype == 8'd5;
      dhcpnak         <= accept && ctx_n.msgtype == 8'd6;
      rx_drop         <= drop;
      if (accept) begin
        yiaddr      <= ctx_n.yiaddr;
        siaddr      <= ctx_n.siaddr;
        server_id   <= ctx_n.server_id;
        subnet_mask <= ctx_n.subnet_mask;
        router      <= ctx_n.router;
        lease_time  <= ctx_n.lease_time;
      end
    end
  end

endmodule
